// File: rtl/sap_ctrl_pkg.sv
// +----------------------------------------------------------------------------+
// | sap_ctrl_pkg: opcodes, T-state indices and control-word type for the       |
// | SAP controller/sequencer.                                                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package sap_ctrl_pkg;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Fetch states sit at fixed ring positions; wait and execute states follow them
  localparam int T1_IDX = 0;
  localparam int T2_IDX = 1;
  localparam int T3_IDX = 2;
  localparam int W1_IDX = 3;

  function automatic int e_idx(input int fetch_wait, input int k);
    return W1_IDX + fetch_wait + k - 1;
  endfunction

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'd0,
    MODE_RUN    = 2'd1,
    MODE_HALTED = 2'd2
  } mode_e;

  typedef struct packed {
    logic pc_inc;
    logic pc_out_bar;
    logic addr_sel;
    logic mar_load_bar;
    logic ram_out_bar;
    logic ir_load_bar;
    logic ir_out_bar;
    logic acc_load_bar;
    logic acc_out;
    logic b_load_bar;
    logic alu_sub;
    logic alu_out;
    logic out_load_bar;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_INACTIVE = '{
    pc_inc:       1'b0,
    pc_out_bar:   1'b1,
    addr_sel:     1'b0,
    mar_load_bar: 1'b1,
    ram_out_bar:  1'b1,
    ir_load_bar:  1'b1,
    ir_out_bar:   1'b1,
    acc_load_bar: 1'b1,
    acc_out:      1'b0,
    b_load_bar:   1'b1,
    alu_sub:      1'b0,
    alu_out:      1'b0,
    out_load_bar: 1'b1
  };

endpackage

`default_nettype wire

// File: rtl/t_state_ring.sv
// +----------------------------------------------------------------------------+
// | t_state_ring: one-hot T-state ring with start, advance and freeze.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module t_state_ring #(
  parameter int NT = 7
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_start,
  input  logic          i_advance,
  input  logic          i_freeze,
  output logic [NT-1:0] o_state
);

  logic [NT-1:0] r_ring;

  // Freeze wins over start/advance so a halted machine keeps its E1 marker
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_ring <= '0;
    end else if (i_freeze) begin
      r_ring <= r_ring;
    end else if (i_start) begin
      r_ring <= NT'(1);
    end else if (i_advance) begin
      r_ring <= {r_ring[NT-2:0], r_ring[NT-1]};
    end
  end

  assign o_state = r_ring;

endmodule

`default_nettype wire

// File: rtl/controller_sequencer.sv
// +----------------------------------------------------------------------------+
// | controller_sequencer: SAP fetch/execute sequencer and opcode decoder.      |
// | Optional SINGLE_STEP_EN macro adds a synchronised 'step' advance input.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module controller_sequencer
  import sap_ctrl_pkg::*;
#(
  parameter int FETCH_WAIT = 1,
  parameter int OPW        = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
`ifdef SINGLE_STEP_EN
  input  logic                  step,
`endif
  input  logic [OPW-1:0]        opcode,
  output logic                  pc_inc,
  output logic                  pc_out_bar,
  output logic                  addr_sel,
  output logic                  mar_load_bar,
  output logic                  ram_out_bar,
  output logic                  ir_load_bar,
  output logic                  ir_out_bar,
  output logic                  acc_load_bar,
  output logic                  acc_out,
  output logic                  b_load_bar,
  output logic                  alu_sub,
  output logic                  alu_out,
  output logic                  out_load_bar,
  output logic                  halt,
  output logic [6+FETCH_WAIT-1:0] t_state
);

  localparam int NT = 6 + FETCH_WAIT;
  localparam int E1 = 3 + FETCH_WAIT;
  localparam int E2 = 4 + FETCH_WAIT;
  localparam int E3 = 5 + FETCH_WAIT;

  localparam logic [OPW-1:0] C_LDA = OPW'(OP_LDA);
  localparam logic [OPW-1:0] C_ADD = OPW'(OP_ADD);
  localparam logic [OPW-1:0] C_SUB = OPW'(OP_SUB);
  localparam logic [OPW-1:0] C_OUT = OPW'(OP_OUT);
  localparam logic [OPW-1:0] C_HLT = OPW'(OP_HLT);

  mode_e         r_mode;
  mode_e         w_mode_nxt;
  logic          w_step;
  logic          w_start;
  logic          w_adv;
  logic          w_freeze;
  logic          w_halt;
  ctrl_word_t    w_cw;
  logic [NT-1:0] w_ring;

`ifdef SINGLE_STEP_EN
  logic r_step_s1;
  logic r_step_s2;
  logic r_step_d;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_step_s1 <= 1'b0;
      r_step_s2 <= 1'b0;
      r_step_d  <= 1'b0;
    end else begin
      r_step_s1 <= step;
      r_step_s2 <= r_step_s1;
      r_step_d  <= r_step_s2;
    end
  end

  assign w_step = r_step_s2 & ~r_step_d;
`else
  assign w_step = 1'b1;
`endif

  t_state_ring #(
    .NT (NT)
  ) u_ring (
    .clk       (clk),
    .rstn      (rstn),
    .i_start   (w_start),
    .i_advance (w_adv),
    .i_freeze  (w_freeze),
    .o_state   (w_ring)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_mode <= MODE_IDLE;
    end else begin
      r_mode <= w_mode_nxt;
    end
  end

  always_comb begin
    w_mode_nxt = r_mode;
    w_start    = 1'b0;
    w_adv      = 1'b0;
    w_freeze   = 1'b0;
    w_halt     = 1'b0;
    w_cw       = CTRL_INACTIVE;
    case (r_mode)
      MODE_IDLE: begin
        if (w_step) begin
          w_mode_nxt = MODE_RUN;
          w_start    = 1'b1;
        end
      end
      MODE_RUN: begin
        w_adv         = w_step;
        w_cw.ir_out_bar = 1'b0;
        if (w_ring[T1_IDX]) begin
          w_cw.pc_out_bar   = 1'b0;
          w_cw.mar_load_bar = 1'b0;
        end
        if (w_ring[T2_IDX]) begin
          w_cw.pc_inc = 1'b1;
        end
        if (w_ring[T3_IDX]) begin
          w_cw.ram_out_bar = 1'b0;
          w_cw.ir_load_bar = 1'b0;
        end
        if (w_ring[E1]) begin
          case (opcode)
            C_LDA, C_ADD, C_SUB: begin
              w_cw.addr_sel     = 1'b1;
              w_cw.mar_load_bar = 1'b0;
            end
            C_OUT: begin
              w_cw.acc_out      = 1'b1;
              w_cw.out_load_bar = 1'b0;
            end
            C_HLT: begin
              // Ring stays parked on E1 so t_state shows where the machine stopped
              w_halt = 1'b1;
              w_adv  = 1'b0;
              if (w_step) begin
                w_mode_nxt = MODE_HALTED;
              end
            end
            default: ;
          endcase
        end
        if (w_ring[E2]) begin
          case (opcode)
            C_LDA: begin
              w_cw.ram_out_bar  = 1'b0;
              w_cw.acc_load_bar = 1'b0;
            end
            C_ADD, C_SUB: begin
              w_cw.ram_out_bar = 1'b0;
              w_cw.b_load_bar  = 1'b0;
              w_cw.alu_sub     = (opcode == C_SUB);
            end
            default: ;
          endcase
        end
        if (w_ring[E3]) begin
          if (opcode == C_ADD || opcode == C_SUB) begin
            w_cw.alu_out      = 1'b1;
            w_cw.acc_load_bar = 1'b0;
            w_cw.alu_sub      = (opcode == C_SUB);
          end
        end
      end
      MODE_HALTED: begin
        w_halt   = 1'b1;
        w_freeze = 1'b1;
      end
      default: begin
        w_mode_nxt = MODE_IDLE;
      end
    endcase
  end

  assign pc_inc       = w_cw.pc_inc;
  assign pc_out_bar   = w_cw.pc_out_bar;
  assign addr_sel     = w_cw.addr_sel;
  assign mar_load_bar = w_cw.mar_load_bar;
  assign ram_out_bar  = w_cw.ram_out_bar;
  assign ir_load_bar  = w_cw.ir_load_bar;
  assign ir_out_bar   = w_cw.ir_out_bar;
  assign acc_load_bar = w_cw.acc_load_bar;
  assign acc_out      = w_cw.acc_out;
  assign b_load_bar   = w_cw.b_load_bar;
  assign alu_sub      = w_cw.alu_sub;
  assign alu_out      = w_cw.alu_out;
  assign out_load_bar = w_cw.out_load_bar;
  assign halt         = w_halt;
  assign t_state      = w_ring;

endmodule

`default_nettype wire
